gate_sweep_unit: RTL and testbench
==================================

GATE_SWEEP_UNIT -- requirements
Module: gate_sweep_unit

Interface
REQ-001 Parameter N_IN, default 3, legal 2..8: number of gate inputs; truth-table width TT = 2**N_IN.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 mode_subtask  input  3  gate select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 constant 0.
REQ-005 signal_in  input  N_IN  manual-evaluation input vector.
REQ-006 start  input  1  sweep request, sampled in IDLE only.
REQ-007 expected_table  input  TT  reference truth table; bit k is the expected output for input vector k.
REQ-008 signal_out  output  1  registered gate output for the currently applied vector.
REQ-009 busy  output  1  high while a sweep runs.
REQ-010 done  output  1  single-cycle pulse at sweep completion.
REQ-011 truth_table  output  TT  captured sweep result; bit k = f(k).
REQ-012 signal_match  output  1  truth_table == expected_table, evaluated at completion.

Function
REQ-013 f(v) SHALL be the N_IN-input reduction selected by mode: AND, OR, ~AND, ~OR, XOR (odd parity), XNOR; modes 6/7 SHALL give 0.
REQ-014 FSM states SHALL be IDLE, SWEEP, DONE; no other reachable state.
REQ-015 IDLE: each edge, signal_out SHALL load f(signal_in) using live mode_subtask (1-cycle latency).
REQ-016 IDLE with start=1: next edge SHALL enter SWEEP, latch mode_subtask, clear count to 0, clear truth_table and signal_match.
REQ-017 SWEEP: each edge SHALL write truth_table[count] and signal_out with f(count) using the latched mode, then increment count.
REQ-018 count SHALL be N_IN+1 bits wide; the edge that writes index TT-1 SHALL move the FSM to DONE; no wrap to 0 inside SWEEP.
REQ-019 busy SHALL be 1 exactly in SWEEP: TT consecutive cycles per sweep.
REQ-020 DONE: done=1 for exactly one cycle; signal_match SHALL load (truth_table == expected_table) on the edge leaving DONE; next state IDLE.
REQ-021 truth_table and signal_match SHALL hold their values in IDLE until the next accepted start.
REQ-022 start in SWEEP or DONE SHALL be ignored; it is not queued.
REQ-023 mode_subtask and signal_in changes during SWEEP SHALL not affect the sweep.
REQ-024 start held high continuously SHALL trigger back-to-back sweeps with exactly one IDLE cycle between DONE and the next SWEEP.
REQ-025 All outputs SHALL be driven from registers; no combinational input-to-output path.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, count=0, signal_out=0, busy=0, done=0, truth_table=0, signal_match=0, latched mode=0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; after release the block SHALL wait for a new start.
REQ-028 First edge after rst_n deasserts SHALL behave as a normal IDLE edge.

Verification
REQ-029 N_IN=3, mode 0, start pulse -> busy high 8 cycles, done one cycle later, truth_table=8'h80; expected_table=8'h80 -> signal_match=1.
REQ-030 N_IN=3 sweeps, modes 1/2/3/4/5 -> truth_table 8'hFE/8'h7F/8'h01/8'h96/8'h69; mode 6 -> 8'h00.
REQ-031 IDLE, mode 0, signal_in 3'b111 then 3'b110 -> signal_out 1 then 0, each one cycle after the input.
REQ-032 Start sweep mode 1; change mode to 0 and pulse start at count 3 -> truth_table=8'hFE, single done, no second sweep.
REQ-033 Assert rst_n=0 at count 5 -> all outputs 0 immediately, no done; new start -> full 8-cycle sweep.
REQ-034 N_IN=4, mode 4, expected_table=16'h6996 -> busy 16 cycles, truth_table=16'h6996, signal_match=1; expected 16'h6997 -> signal_match=0.

Source files
------------

// File: rtl/gate_sweep_unit_if.sv
// Bundles the gate sweep unit's control and result signals.
// master: drives mode_subtask, signal_in, start and expected_table,
//         and observes the results.
// slave:  the gate sweep unit itself, which drives signal_out, busy,
//         done, truth_table and signal_match.
interface gate_sweep_unit_if #(
   parameter int unsigned N_IN = 3
);
   localparam int unsigned TT = 1 << N_IN;

   logic [2:0]      mode_subtask;
   logic [N_IN-1:0] signal_in;
   logic            start;
   logic [TT-1:0]   expected_table;
   logic            signal_out;
   logic            busy;
   logic            done;
   logic [TT-1:0]   truth_table;
   logic            signal_match;

   modport master (
      output mode_subtask, signal_in, start, expected_table,
      input  signal_out, busy, done, truth_table, signal_match
   );

   modport slave (
      input  mode_subtask, signal_in, start, expected_table,
      output signal_out, busy, done, truth_table, signal_match
   );
endinterface

// File: rtl/gate_sweep_unit.sv
// Gate sweep unit: evaluates a selectable N_IN-input reduction gate on a
// manual input vector while idle, and on request sweeps every input
// vector to capture the full truth table and compare it against a
// reference table.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of gate_sweep_unit_if (mode/vector/start/reference
//            in; signal_out/busy/done/truth_table/signal_match out)
module gate_sweep_unit #(
   parameter int unsigned N_IN = 3
) (
   input logic             clk,
   input logic             rst_n,
   gate_sweep_unit_if.slave bus
);
   localparam int unsigned TT = 1 << N_IN;
   localparam int unsigned CW = N_IN + 1;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] SWEEP = 2'b01;
   localparam logic [1:0] DONE  = 2'b10;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    mode_q, mode_d;
   logic          signal_out_q, signal_out_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [TT-1:0] truth_table_q, truth_table_d;
   logic          signal_match_q, signal_match_d;
   logic          sweep_bit;

   // Reduction gate selected by mode; modes 6/7 give constant 0.
   function automatic logic gate_f(input logic [2:0] m, input logic [N_IN-1:0] v);
      logic r;
      r = 1'b0;
      case (m)
         3'd0:    r = &v;
         3'd1:    r = |v;
         3'd2:    r = ~&v;
         3'd3:    r = ~|v;
         3'd4:    r = ^v;
         3'd5:    r = ~^v;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Next-state and output logic.
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      mode_d         = mode_q;
      signal_out_d   = signal_out_q;
      truth_table_d  = truth_table_q;
      signal_match_d = signal_match_q;
      sweep_bit      = gate_f(mode_q, count_q[N_IN-1:0]);

      case (state_q)
         IDLE: begin
            signal_out_d = gate_f(bus.mode_subtask, bus.signal_in);
            if (bus.start) begin
               state_d        = SWEEP;
               mode_d         = bus.mode_subtask;
               count_d        = '0;
               truth_table_d  = '0;
               signal_match_d = 1'b0;
            end
         end
         SWEEP: begin
            truth_table_d[count_q[N_IN-1:0]] = sweep_bit;
            signal_out_d = sweep_bit;
            count_d      = count_q + CW'(1);
            // Leave on the write of the last index so count never wraps here.
            if (count_q == CW'(TT - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            signal_match_d = (truth_table_q == bus.expected_table);
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Status flags are registered copies of the upcoming state.
      busy_d = (state_d == SWEEP);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         count_q        <= '0;
         mode_q         <= '0;
         signal_out_q   <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         truth_table_q  <= '0;
         signal_match_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         mode_q         <= mode_d;
         signal_out_q   <= signal_out_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         truth_table_q  <= truth_table_d;
         signal_match_q <= signal_match_d;
      end
   end

   assign bus.signal_out   = signal_out_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.truth_table  = truth_table_q;
   assign bus.signal_match = signal_match_q;
endmodule

// File: tb/tb_gate_sweep_unit.sv
// Directed bench for gate_sweep_unit at N_IN=3 and N_IN=4.
module tb_gate_sweep_unit;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   gate_sweep_unit_if #(.N_IN(3)) bus3 ();
   gate_sweep_unit_if #(.N_IN(4)) bus4 ();

   gate_sweep_unit #(.N_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
   gate_sweep_unit #(.N_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one N_IN=3 sweep; returns busy cycle count and done pulses seen.
   task automatic sweep3(input logic [2:0] m, input logic [7:0] exp_tt,
                         output int busy_n, output int done_n);
      bus3.mode_subtask   = m;
      bus3.expected_table = exp_tt;
      bus3.start          = 1'b1;
      tick();
      bus3.start = 1'b0;
      busy_n = 0;
      done_n = 0;
      while (bus3.busy && busy_n < 64) begin
         busy_n++;
         tick();
      end
      if (bus3.done) done_n++;
      tick();
      if (bus3.done) done_n++;
   endtask

   // Runs one N_IN=4 sweep; also reports signal_match while sweeping.
   task automatic sweep4(input logic [2:0] m, input logic [15:0] exp_tt,
                         output int busy_n, output int done_n, output logic match_mid);
      bus4.mode_subtask   = m;
      bus4.expected_table = exp_tt;
      bus4.start          = 1'b1;
      tick();
      bus4.start = 1'b0;
      match_mid  = bus4.signal_match;
      busy_n = 0;
      done_n = 0;
      while (bus4.busy && busy_n < 64) begin
         busy_n++;
         tick();
      end
      if (bus4.done) done_n++;
      tick();
      if (bus4.done) done_n++;
   endtask

   logic [2:0] mode_tab [6];
   logic [7:0] tt_tab   [6];

   initial begin
      int   b;
      int   d;
      int   cyc;
      logic mm;

      n_checks = 0;
      n_fail   = 0;
      mode_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      tt_tab   = '{8'hFE, 8'h7F, 8'h01, 8'h96, 8'h69, 8'h00};

      rst_n = 1'b0;
      bus3.mode_subtask = 3'd0; bus3.signal_in = '0; bus3.start = 1'b0; bus3.expected_table = '0;
      bus4.mode_subtask = 3'd0; bus4.signal_in = '0; bus4.start = 1'b0; bus4.expected_table = '0;
      #1;
      check_eq("rst_signal_out", 32'(bus3.signal_out), 32'd0);
      check_eq("rst_busy", 32'(bus3.busy), 32'd0);
      check_eq("rst_done", 32'(bus3.done), 32'd0);
      check_eq("rst_tt", 32'(bus3.truth_table), 32'd0);
      check_eq("rst_match", 32'(bus3.signal_match), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Manual evaluation in IDLE, one-cycle latency.
      bus3.mode_subtask = 3'd0;
      bus3.signal_in    = 3'b111;
      tick();
      check_eq("idle_and_111", 32'(bus3.signal_out), 32'd1);
      bus3.signal_in = 3'b110;
      check_eq("idle_latency", 32'(bus3.signal_out), 32'd1);
      tick();
      check_eq("idle_and_110", 32'(bus3.signal_out), 32'd0);
      check_eq("idle_busy", 32'(bus3.busy), 32'd0);

      // AND sweep with matching reference.
      sweep3(3'd0, 8'h80, b, d);
      check_eq("and_busy_cycles", 32'(b), 32'd8);
      check_eq("and_done_pulses", 32'(d), 32'd1);
      check_eq("and_tt", 32'(bus3.truth_table), 32'h80);
      check_eq("and_match", 32'(bus3.signal_match), 32'd1);

      // Remaining modes.
      for (int i = 0; i < 6; i++) begin
         sweep3(mode_tab[i], tt_tab[i], b, d);
         check_eq($sformatf("mode%0d_busy", mode_tab[i]), 32'(b), 32'd8);
         check_eq($sformatf("mode%0d_tt", mode_tab[i]), 32'(bus3.truth_table), 32'(tt_tab[i]));
         check_eq($sformatf("mode%0d_match", mode_tab[i]), 32'(bus3.signal_match), 32'd1);
      end

      // Mismatching reference, then results hold across IDLE activity.
      sweep3(3'd1, 8'h80, b, d);
      check_eq("mism_tt", 32'(bus3.truth_table), 32'hFE);
      check_eq("mism_match", 32'(bus3.signal_match), 32'd0);
      bus3.mode_subtask = 3'd4;
      bus3.signal_in    = 3'b001;
      tick();
      tick();
      check_eq("hold_tt", 32'(bus3.truth_table), 32'hFE);
      check_eq("hold_match", 32'(bus3.signal_match), 32'd0);
      check_eq("hold_idle_xor", 32'(bus3.signal_out), 32'd1);

      // Mode change and start during a sweep are ignored.
      bus3.mode_subtask = 3'd1;
      bus3.start        = 1'b1;
      tick();
      bus3.start = 1'b0;
      b = 0;
      for (int k = 0; k < 3; k++) begin
         if (bus3.busy) b++;
         tick();
      end
      bus3.mode_subtask = 3'd0;
      bus3.signal_in    = 3'b111;
      bus3.start        = 1'b1;
      if (bus3.busy) b++;
      tick();
      bus3.start = 1'b0;
      cyc = 0;
      while (bus3.busy && cyc < 64) begin
         b++;
         cyc++;
         tick();
      end
      d = 0;
      if (bus3.done) d++;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus3.done) d++;
         if (bus3.busy) b++;
      end
      check_eq("ign_busy_cycles", 32'(b), 32'd8);
      check_eq("ign_done_pulses", 32'(d), 32'd1);
      check_eq("ign_tt", 32'(bus3.truth_table), 32'hFE);

      // Reset in mid-sweep aborts with no done.
      bus3.mode_subtask = 3'd1;
      bus3.start        = 1'b1;
      tick();
      bus3.start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      check_eq("abort_pre_tt", 32'(bus3.truth_table), 32'h1E);
      check_eq("abort_pre_busy", 32'(bus3.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", 32'(bus3.busy), 32'd0);
      check_eq("abort_tt", 32'(bus3.truth_table), 32'd0);
      check_eq("abort_signal_out", 32'(bus3.signal_out), 32'd0);
      check_eq("abort_match", 32'(bus3.signal_match), 32'd0);
      d = 0;
      @(negedge clk);
      if (bus3.done) d++;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus3.done || bus3.busy) d++;
      end
      check_eq("abort_quiet", 32'(d), 32'd0);
      sweep3(3'd1, 8'hFE, b, d);
      check_eq("post_rst_busy", 32'(b), 32'd8);
      check_eq("post_rst_done", 32'(d), 32'd1);
      check_eq("post_rst_tt", 32'(bus3.truth_table), 32'hFE);

      // Start held high: one IDLE cycle between DONE and next SWEEP.
      bus3.mode_subtask   = 3'd4;
      bus3.expected_table = 8'h96;
      bus3.start          = 1'b1;
      tick();
      cyc = 0;
      while (bus3.busy && cyc < 64) begin
         cyc++;
         tick();
      end
      check_eq("b2b_busy_cycles", 32'(cyc), 32'd8);
      check_eq("b2b_done", 32'(bus3.done), 32'd1);
      tick();
      check_eq("b2b_gap_busy", 32'(bus3.busy), 32'd0);
      check_eq("b2b_gap_done", 32'(bus3.done), 32'd0);
      tick();
      check_eq("b2b_restart", 32'(bus3.busy), 32'd1);
      bus3.start = 1'b0;
      cyc = 0;
      while (bus3.busy && cyc < 64) begin
         cyc++;
         tick();
      end
      tick();
      check_eq("b2b_second_tt", 32'(bus3.truth_table), 32'h96);

      // Wider instance.
      sweep4(3'd4, 16'h6996, b, d, mm);
      check_eq("n4_busy_cycles", 32'(b), 32'd16);
      check_eq("n4_done_pulses", 32'(d), 32'd1);
      check_eq("n4_tt", 32'(bus4.truth_table), 32'h6996);
      check_eq("n4_match", 32'(bus4.signal_match), 32'd1);
      sweep4(3'd4, 16'h6997, b, d, mm);
      check_eq("n4_match_cleared", 32'(mm), 32'd0);
      check_eq("n4_mism_tt", 32'(bus4.truth_table), 32'h6996);
      check_eq("n4_mism_match", 32'(bus4.signal_match), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
